// File: rtl/dma_axi_if_mo.sv
// DMA-to-AXI4 master interface with multiple outstanding read and write bursts.
// Each accepted burst keeps its own {addr, strb, alen} context. Narrow-transfer
// alignment and error addresses therefore follow the right burst when bursts
// overlap. AR/AW are registered and hold their payload until the handshake.
module dma_axi_if_mo #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 512,
   parameter int MAX_OUTSTD = 4,
   localparam int STRB_W    = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req_valid_i,
   output logic              rd_req_ready_o,
   input  logic [ADDR_W-1:0] rd_req_addr_i,
   input  logic [7:0]        rd_req_alen_i,
   input  logic [2:0]        rd_req_size_i,
   input  logic [STRB_W-1:0] rd_req_strb_i,
   input  logic              wr_req_valid_i,
   output logic              wr_req_ready_o,
   input  logic [ADDR_W-1:0] wr_req_addr_i,
   input  logic [7:0]        wr_req_alen_i,
   input  logic [2:0]        wr_req_size_i,
   input  logic [STRB_W-1:0] wr_req_strb_i,
   output logic [ADDR_W-1:0] m_araddr_o,
   output logic [7:0]        m_arlen_o,
   output logic [2:0]        m_arsize_o,
   output logic [1:0]        m_arburst_o,
   output logic [2:0]        m_arprot_o,
   output logic [3:0]        m_arid_o,
   output logic              m_arvalid_o,
   input  logic              m_arready_i,
   input  logic [DATA_W-1:0] m_rdata_i,
   input  logic [1:0]        m_rresp_i,
   input  logic              m_rlast_i,
   input  logic              m_rvalid_i,
   output logic              m_rready_o,
   output logic [ADDR_W-1:0] m_awaddr_o,
   output logic [7:0]        m_awlen_o,
   output logic [2:0]        m_awsize_o,
   output logic [1:0]        m_awburst_o,
   output logic [2:0]        m_awprot_o,
   output logic [3:0]        m_awid_o,
   output logic              m_awvalid_o,
   input  logic              m_awready_i,
   output logic [DATA_W-1:0] m_wdata_o,
   output logic [STRB_W-1:0] m_wstrb_o,
   output logic              m_wlast_o,
   output logic              m_wvalid_o,
   input  logic              m_wready_i,
   input  logic [1:0]        m_bresp_i,
   input  logic              m_bvalid_i,
   output logic              m_bready_o,
   output logic              fifo_wr_o,
   output logic [DATA_W-1:0] fifo_wdata_o,
   input  logic              fifo_full_i,
   output logic              fifo_rd_o,
   input  logic [DATA_W-1:0] fifo_rdata_i,
   input  logic              fifo_empty_i,
   input  logic              dma_active_i,
   input  logic              clear_dma_i,
   output logic              axi_pend_txn_o,
   output logic              err_valid_o,
   output logic              err_src_o,
   output logic [ADDR_W-1:0] err_addr_o
);

   localparam int PTR_W = $clog2(MAX_OUTSTD);
   localparam int CNT_W = PTR_W + 1;
   localparam int SH_W  = $clog2(STRB_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTD);

   // Byte index of the lowest enabled strobe; an empty strobe means no shift.
   function automatic logic [SH_W-1:0] lowest_idx(input logic [STRB_W-1:0] s);
      lowest_idx = '0;
      for (int i = STRB_W - 1; i >= 0; i--)
         if (s[i]) lowest_idx = SH_W'(i);
   endfunction

   logic              arvalid_q, awvalid_q;
   logic [CNT_W-1:0]  rd_cnt, wr_cnt;
   logic [PTR_W-1:0]  rd_wptr, rd_rptr;
   logic [PTR_W:0]    wr_wptr, wr_wptr_w, wr_bptr;
   logic [7:0]        beat_cnt;
   logic [ADDR_W-1:0] rd_addr_mem [MAX_OUTSTD];
   logic [STRB_W-1:0] rd_strb_mem [MAX_OUTSTD];
   logic [ADDR_W-1:0] wr_addr_mem [MAX_OUTSTD];
   logic [STRB_W-1:0] wr_strb_mem [MAX_OUTSTD];
   logic [7:0]        wr_alen_mem [MAX_OUTSTD];
   logic              rd_acc, wr_acc, r_hs, rd_pop, w_hs, w_done, b_hs;
   logic              rd_err, wr_err;
   logic [STRB_W-1:0] rd_strb_head, w_strb;
   logic [DATA_W-1:0] rd_masked;

   assign rd_req_ready_o = dma_active_i & (~arvalid_q | m_arready_i) & (rd_cnt < CNT_MAX);
   assign wr_req_ready_o = dma_active_i & (~awvalid_q | m_awready_i) & (wr_cnt < CNT_MAX);
   assign rd_acc = rd_req_valid_i & rd_req_ready_o;
   assign wr_acc = wr_req_valid_i & wr_req_ready_o;

   assign m_arvalid_o = arvalid_q;
   assign m_arburst_o = 2'b01;
   assign m_arprot_o  = 3'b010;
   assign m_arid_o    = 4'd0;
   assign m_awvalid_o = awvalid_q;
   assign m_awburst_o = 2'b01;
   assign m_awprot_o  = 3'b010;
   assign m_awid_o    = 4'd0;

   assign m_rready_o   = ~fifo_full_i;
   assign r_hs         = m_rvalid_i & m_rready_o;
   assign rd_pop       = r_hs & m_rlast_i;
   assign fifo_wr_o    = r_hs;
   assign rd_strb_head = rd_strb_mem[rd_rptr];

   // Zero the bytes the head read burst did not ask for before aligning to bit 0.
   always_comb begin
      rd_masked = '0;
      for (int i = 0; i < STRB_W; i++)
         rd_masked[8*i +: 8] = rd_strb_head[i] ? m_rdata_i[8*i +: 8] : 8'h00;
   end
   assign fifo_wdata_o = rd_masked >> {lowest_idx(rd_strb_head), 3'b000};

   assign w_strb     = wr_strb_mem[wr_wptr_w[PTR_W-1:0]];
   assign m_wvalid_o = ~fifo_empty_i & (wr_wptr_w != wr_wptr);
   assign m_wstrb_o  = w_strb;
   assign m_wdata_o  = fifo_rdata_i << {lowest_idx(w_strb), 3'b000};
   assign m_wlast_o  = (beat_cnt == wr_alen_mem[wr_wptr_w[PTR_W-1:0]]);
   assign w_hs       = m_wvalid_o & m_wready_i;
   assign w_done     = w_hs & m_wlast_o;
   assign fifo_rd_o  = w_hs;
   assign m_bready_o = 1'b1;
   assign b_hs       = m_bvalid_i;

   assign rd_err = r_hs & m_rresp_i[1];
   assign wr_err = b_hs & m_bresp_i[1];
   assign axi_pend_txn_o = (rd_cnt != '0) | (wr_cnt != '0) | arvalid_q | awvalid_q;

   // AR register: load on acceptance, hold until the slave takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         arvalid_q  <= 1'b0;
         m_araddr_o <= '0;
         m_arlen_o  <= '0;
         m_arsize_o <= '0;
      end else if (rd_acc) begin
         arvalid_q  <= 1'b1;
         m_araddr_o <= rd_req_addr_i;
         m_arlen_o  <= rd_req_alen_i;
         m_arsize_o <= rd_req_size_i;
      end else if (m_arready_i) begin
         arvalid_q  <= 1'b0;
      end
   end

   // AW register: load on acceptance, hold until the slave takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         awvalid_q  <= 1'b0;
         m_awaddr_o <= '0;
         m_awlen_o  <= '0;
         m_awsize_o <= '0;
      end else if (wr_acc) begin
         awvalid_q  <= 1'b1;
         m_awaddr_o <= wr_req_addr_i;
         m_awlen_o  <= wr_req_alen_i;
         m_awsize_o <= wr_req_size_i;
      end else if (m_awready_i) begin
         awvalid_q  <= 1'b0;
      end
   end

   // Context storage needs no reset: entries are only read behind a valid pointer.
   always_ff @(posedge clk) begin
      if (rd_acc) begin
         rd_addr_mem[rd_wptr] <= rd_req_addr_i;
         rd_strb_mem[rd_wptr] <= rd_req_strb_i;
      end
      if (wr_acc) begin
         wr_addr_mem[wr_wptr[PTR_W-1:0]] <= wr_req_addr_i;
         wr_strb_mem[wr_wptr[PTR_W-1:0]] <= wr_req_strb_i;
         wr_alen_mem[wr_wptr[PTR_W-1:0]] <= wr_req_alen_i;
      end
   end

   // Read context pointers and in-flight count (push on accept, pop on rlast).
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_wptr <= '0;
         rd_rptr <= '0;
         rd_cnt  <= '0;
      end else begin
         if (rd_acc) rd_wptr <= rd_wptr + 1'b1;
         if (rd_pop) rd_rptr <= rd_rptr + 1'b1;
         case ({rd_acc, rd_pop})
            2'b10:   rd_cnt <= rd_cnt + 1'b1;
            2'b01:   rd_cnt <= rd_cnt - 1'b1;
            default: rd_cnt <= rd_cnt;
         endcase
      end
   end

   // Write context pointers: W-ptr follows data beats, B-ptr follows responses.
   // The extra pointer bit tells a full context FIFO from an empty one.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_wptr   <= '0;
         wr_wptr_w <= '0;
         wr_bptr   <= '0;
         wr_cnt    <= '0;
         beat_cnt  <= '0;
      end else begin
         if (wr_acc) wr_wptr <= wr_wptr + 1'b1;
         if (b_hs)   wr_bptr <= wr_bptr + 1'b1;
         if (w_hs) begin
            beat_cnt <= w_done ? 8'd0 : beat_cnt + 1'b1;
            if (w_done) wr_wptr_w <= wr_wptr_w + 1'b1;
         end
         case ({wr_acc, b_hs})
            2'b10:   wr_cnt <= wr_cnt + 1'b1;
            2'b01:   wr_cnt <= wr_cnt - 1'b1;
            default: wr_cnt <= wr_cnt;
         endcase
      end
   end

   // First error sticks until the DMA clears it; a read error beats a write error.
   always_ff @(posedge clk) begin
      if (rst || clear_dma_i) begin
         err_valid_o <= 1'b0;
         err_src_o   <= 1'b0;
         err_addr_o  <= '0;
      end else if (!err_valid_o) begin
         if (rd_err) begin
            err_valid_o <= 1'b1;
            err_src_o   <= 1'b0;
            err_addr_o  <= rd_addr_mem[rd_rptr];
         end else if (wr_err) begin
            err_valid_o <= 1'b1;
            err_src_o   <= 1'b1;
            err_addr_o  <= wr_addr_mem[wr_bptr[PTR_W-1:0]];
         end
      end
   end

endmodule

// File: doc/dma_axi_if_mo.md
# dma_axi_if_mo

Parametrised successor of the DMA-to-AXI master interface that supports multiple outstanding read and write bursts. It sits between the DMA read/write streamers, the DMA data FIFO and the SoC AXI4 master port. Each accepted burst keeps its own address/strobe/length context, so narrow-transfer alignment and error addresses stay correct when bursts overlap. Address channels are registered and AXI-compliant: valid is held, payload is stable.

## Interface
Parameters
- ADDR_W, 32, AXI address width
- DATA_W, 512, AXI data width; STRB_W = DATA_W/8
- MAX_OUTSTD, 4, max in-flight bursts per direction (context FIFO depth, power of 2, ≥2)

Ports (one clock; reset is synchronous and active-high)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req_valid_i / rd_req_ready_o  in/out  1  read streamer handshake
- rd_req_addr_i, rd_req_alen_i, rd_req_size_i, rd_req_strb_i  in  ADDR_W, 8, 3, STRB_W  read burst descriptor
- wr_req_valid_i / wr_req_ready_o, wr_req_addr_i, wr_req_alen_i, wr_req_size_i, wr_req_strb_i  same for writes
- m_ar*  out  araddr/arlen/arsize/arburst/arprot/arid/arvalid; m_arready_i in
- m_rdata_i, m_rresp_i, m_rlast_i, m_rvalid_i  in; m_rready_o  out
- m_aw*  out  (as AR); m_awready_i  in
- m_wdata_o, m_wstrb_o, m_wlast_o, m_wvalid_o  out; m_wready_i  in
- m_bresp_i, m_bvalid_i  in; m_bready_o  out
- fifo_wr_o, fifo_wdata_o (DATA_W)  out; fifo_full_i  in  write side of the DMA FIFO
- fifo_rd_o  out; fifo_rdata_i (DATA_W), fifo_empty_i  in  read side of the DMA FIFO
- dma_active_i, clear_dma_i  in  1  from the DMA FSM
- axi_pend_txn_o  out  1  any burst in flight in either direction
- err_valid_o, err_src_o (1: 0=RD, 1=WR), err_addr_o (ADDR_W)  out  captured error

## Operation
- Read issue: rd_req_ready_o = dma_active_i & (~arvalid_q | m_arready_i) & (rd_cnt < MAX_OUTSTD). On acceptance, the descriptor is registered onto AR, with arburst=INCR, arprot=3'b010, arid=0. It is also pushed {addr, strb} into the RD context FIFO, and rd_cnt increments.
- Read data:
  - m_rready_o = ~fifo_full_i.
  - On each R beat handshake, fifo_wr_o=1. fifo_wdata_o = rdata with bytes whose head-context strb bit is 0 zeroed, then shifted right by 8×(index of the lowest set strb bit); strb=0 gives no shift.
  - On an rlast handshake, the head context pops and rd_cnt decrements.
- Write issue: same gating, using wr_cnt. The context {addr, strb, alen} is pushed into the WR context FIFO, which has two read pointers: W-ptr and B-ptr.
- Write data:
  - m_wvalid_o = ~fifo_empty_i & (W-ptr ≠ write ptr).
  - wdata = fifo_rdata_i shifted left by 8×(lowest set strb index); wstrb = context strb.
  - wlast = (beat_cnt == context alen).
  - fifo_rd_o = m_wvalid_o & m_wready_i. beat_cnt increments per beat; on wlast it returns to 0 and W-ptr advances.
- Write response: m_bready_o=1 always. A B handshake advances B-ptr and decrements wr_cnt.
- Simultaneous push and pop of a counter in the same cycle leaves it unchanged.
- Errors:
  - Triggered by rresp∈{2,3} on any R beat, or bresp∈{2,3}.
  - The first error captures src and the address from the RD head or B-ptr context; further errors are ignored until clear_dma_i.
  - If read and write errors occur in the same cycle, the read error wins.
  - clear_dma_i zeroes err_*.
- dma_active_i=0 blocks only new request acceptance. Registered AR/AW still complete, and R/W/B drain normally. axi_pend_txn_o = (rd_cnt≠0)|(wr_cnt≠0)|arvalid_q|awvalid_q.

## Timing
- Reset: all valids, fifo_wr_o, fifo_rd_o, beat_cnt, both counters, context pointers, err_* and axi_pend_txn_o are 0. m_rready_o and m_bready_o follow their combinational rules.
- A request accepted at edge N drives m_arvalid/m_awvalid high from N+1 until the handshake. Payload is stable while valid is asserted.
- Back-to-back acceptance is possible: ready is high in the same cycle as the AR/AW handshake.
- R to FIFO is combinational (0 cycles). FIFO to W is combinational.
- The full-to-not-full and empty-to-not-empty transitions take effect in the same cycle.
- A burst of alen=0 is a single beat with wlast=1.
- Rst asserted mid-burst drops all state at the next edge.

## Test plan
- Single read: addr 0x1000, alen 3, strb 0xF0 (bytes 4..7) → arvalid 1 cycle after accept; 4 FIFO writes, each = rdata[63:32] in bits [31:0], upper bits zero; pend falls 1 cycle after rlast.
- Outstanding limit (MAX_OUTSTD=4, arready=1, rvalid held 0) → exactly 4 ARs issued, rd_req_ready_o=0 on the 5th; one rlast → 5th accepted next cycle.
- Two overlapping writes, strb 0x0F then 0xF0, alen 1 each → beats 0–1 use wstrb 0x0F with no shift, beats 2–3 use 0xF0 with data<<32; wlast on beats 1 and 3.
- Backpressure: arready/awready low for 5 cycles → address payload stable, valid held; fifo_full_i=1 → rready=0, no fifo_wr.
- Errors: bresp=2 on 2nd write (addr 0x2040) then rresp=3 → err_src=WR, err_addr=0x2040 latched; clear_dma_i → all zero; same-cycle R+B errors → src=RD.
- Drop dma_active_i with 2 reads in flight → no new AR accepted, both drain, pend deasserts after the last rlast; rst mid-burst → all outputs at reset values next cycle.
